// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, stall
// encoding, load opcodes and the layout of the EX->MEM bus.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 151;
    localparam int MEM_TO_WB_WD = 137;
    localparam int MEM_TO_ID_WD = 105;
    localparam int StallBus     = 6;
    localparam int STALL_WD     = StallBus;

    // Stall vector bit positions and encoding
    localparam int   STALL_MEM = 3;
    localparam int   STALL_WB  = 4;
    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;

    // Load opcodes carried in ld_type
    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LW  = 6'b100011;

    // EX->MEM bus layout, MSB first
    typedef struct packed {
        logic [1:0]  addr_lo;
        logic [63:0] hl_wdata;
        logic [1:0]  hl_waddr;
        logic        hl_we;
        logic [5:0]  ld_type;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half of the SRAM word and
// sign- or zero-extends it according to the load opcode.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [5:0]  ld_type,
    output logic [31:0] result
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = byte_lane[addr_lo];
    // Halves ignore addr_lo[0]: misaligned halves read the aligned half
    assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Extend the selected lane; unknown opcodes return the whole word
    always_comb begin
        result = rdata;
        case (ld_type)
            LB:      result = {{24{sel_byte[7]}}, sel_byte};
            LBU:     result = {24'd0, sel_byte};
            LH:      result = {{16{sel_half[15]}}, sel_half};
            LHU:     result = {16'd0, sel_half};
            LW:      result = rdata;
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the EX->MEM bus under stall
// control, freezes SRAM read data across MEM stalls and builds the
// MEM->WB and MEM->ID forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    ex_to_mem_t  mem_reg;
    logic [31:0] rdata_hold;
    logic        hold_valid;
    logic [31:0] rdata_eff;
    logic [31:0] aligned_data;
    logic [31:0] rf_wdata;
    logic        is_load;
    logic        unused_stall;

    // Only the MEM and WB stall bits matter to this stage
    assign unused_stall = ^{stall[5], stall[2:0]};

    // Stage register plus read-data freeze: the SRAM only presents data in
    // the first MEM cycle, so a stalled load snapshots it on the first
    // stalled edge and keeps using that copy until it leaves the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_reg    <= '0;
            rdata_hold <= '0;
            hold_valid <= 1'b0;
        end else if (stall[STALL_MEM] == Stop && stall[STALL_WB] == NoStop) begin
            mem_reg    <= '0;
            hold_valid <= 1'b0;
        end else if (stall[STALL_MEM] == NoStop) begin
            mem_reg    <= ex_to_mem_t'(ex_to_mem_bus);
            hold_valid <= 1'b0;
        end else if (!hold_valid) begin
            rdata_hold <= data_sram_rdata;
            hold_valid <= 1'b1;
        end
    end

    assign rdata_eff = hold_valid ? rdata_hold : data_sram_rdata;

    load_align u_load_align (
        .rdata   (rdata_eff),
        .addr_lo (mem_reg.addr_lo),
        .ld_type (mem_reg.ld_type),
        .result  (aligned_data)
    );

    // Stores and ALU ops write back the EX result; only true loads use SRAM data
    assign is_load  = mem_reg.ram_en && (mem_reg.ram_wen == 4'd0) && mem_reg.sel_rf_res;
    assign rf_wdata = is_load ? aligned_data : mem_reg.ex_result;

    assign mem_to_wb_bus = {mem_reg.hl_wdata, mem_reg.hl_waddr, mem_reg.hl_we,
                            mem_reg.pc, mem_reg.rf_we, mem_reg.rf_waddr, rf_wdata};

    assign mem_to_id_bus = {mem_reg.hl_wdata, mem_reg.hl_waddr, mem_reg.hl_we,
                            mem_reg.rf_we, mem_reg.rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/stall/bubble cases followed by random
// traffic, checked against a behavioural model through a scoreboard queue.
module tb_mem_stage;

    typedef struct packed {
        logic [1:0]  addr_lo;
        logic [63:0] hl_wdata;
        logic [1:0]  hl_waddr;
        logic        hl_we;
        logic [5:0]  ld_type;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } instr_t;

    typedef struct {
        logic [136:0] wb;
        logic [104:0] id;
        string        name;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [150:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [136:0] mem_to_wb_bus;
    logic [104:0] mem_to_id_bus;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Model state: instruction currently in MEM, how many edges it has been
    // stalled there, and the SRAM word it saw in its first MEM cycle.
    instr_t      cur;
    int          mem_cycles = 0;
    logic [31:0] first_rdata = '0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    function automatic logic [31:0] exp_wdata(instr_t i, logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        if (!(i.ram_en && i.ram_wen == 4'd0 && i.sel)) return i.ex_result;
        b = rd >> (8 * i.addr_lo);
        h = rd >> (16 * i.addr_lo[1]);
        case (i.ld_type)
            6'b100000: return int'(byte'(b[7:0]));
            6'b100100: return {24'd0, b[7:0]};
            6'b100001: return int'(shortint'(h[15:0]));
            6'b100101: return {16'd0, h[15:0]};
            default:   return rd;
        endcase
    endfunction

    // Apply what the DUT saw at the edge that just happened
    task automatic model_edge();
        if (rst || !stall[3] || !stall[4]) begin
            if (rst || stall[3]) cur = '0;
            else                 cur = instr_t'(ex_to_mem_bus);
            mem_cycles = 0;
        end else begin
            mem_cycles++;
        end
    endtask

    task automatic push_expected(input string name);
        exp_t        e;
        logic [31:0] rd;
        logic [31:0] wd;
        if (mem_cycles == 0) first_rdata = data_sram_rdata;
        rd = first_rdata;
        wd = exp_wdata(cur, rd);
        e.wb   = {cur.hl_wdata, cur.hl_waddr, cur.hl_we, cur.pc, cur.rf_we, cur.rf_waddr, wd};
        e.id   = {cur.hl_wdata, cur.hl_waddr, cur.hl_we, cur.rf_we, cur.rf_waddr, wd};
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic [5:0] st, input instr_t ins,
                        input logic [31:0] rd, input string name);
        @(posedge clk);
        model_edge();
        #1;
        rst             = r;
        stall           = st;
        ex_to_mem_bus   = ins;
        data_sram_rdata = rd;
        push_expected(name);
    endtask

    function automatic instr_t mk_load(logic [5:0] op, logic [1:0] a, logic [4:0] wa);
        instr_t i;
        i           = '0;
        i.ld_type   = op;
        i.addr_lo   = a;
        i.ram_en    = 1'b1;
        i.sel       = 1'b1;
        i.rf_we     = 1'b1;
        i.rf_waddr  = wa;
        i.pc        = $urandom;
        i.ex_result = $urandom;
        return i;
    endfunction

    function automatic instr_t mk_alu(logic [31:0] res);
        instr_t i;
        i           = '0;
        i.rf_we     = 1'b1;
        i.rf_waddr  = 5'($urandom);
        i.pc        = $urandom;
        i.ex_result = res;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i = '0;
        case ($urandom_range(0, 3))
            0: begin
                case ($urandom_range(0, 5))
                    0: i = mk_load(6'b100000, 2'($urandom), 5'($urandom));
                    1: i = mk_load(6'b100100, 2'($urandom), 5'($urandom));
                    2: i = mk_load(6'b100001, 2'($urandom), 5'($urandom));
                    3: i = mk_load(6'b100101, 2'($urandom), 5'($urandom));
                    4: i = mk_load(6'b100011, 2'($urandom), 5'($urandom));
                    default: i = mk_load(6'($urandom), 2'($urandom), 5'($urandom));
                endcase
            end
            1: begin
                i           = mk_alu($urandom);
                i.rf_we     = 1'b0;
                i.ram_en    = 1'b1;
                i.ram_wen   = 4'($urandom_range(1, 15));
                i.addr_lo   = 2'($urandom);
                i.ld_type   = 6'($urandom);
            end
            default: begin
                i          = mk_alu($urandom);
                i.hl_we    = 1'($urandom);
                i.hl_waddr = 2'($urandom);
                i.hl_wdata = {$urandom, $urandom};
            end
        endcase
        return i;
    endfunction

    function automatic logic [5:0] rand_stall();
        int r;
        r = $urandom_range(0, 99);
        if (r < 55)      return 6'($urandom) & 6'b100111;
        else if (r < 75) return (6'($urandom) & 6'b100111) | 6'b011000;
        else if (r < 90) return (6'($urandom) & 6'b100111) | 6'b001000;
        else             return (6'($urandom) & 6'b100111) | 6'b010000;
    endfunction

    // Monitor: compare both buses against the oldest expectation each cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if (mem_to_wb_bus !== e.wb) begin
                    bad++;
                    $display("FAIL %s wb: got %h want %h", e.name, mem_to_wb_bus, e.wb);
                end
                total++;
                if (mem_to_id_bus !== e.id) begin
                    bad++;
                    $display("FAIL %s id: got %h want %h", e.name, mem_to_id_bus, e.id);
                end
            end
        end
    end

    initial begin
        instr_t pt;
        instr_t st;
        rst             = 1'b1;
        stall           = 6'($urandom);
        ex_to_mem_bus   = rand_instr();
        data_sram_rdata = $urandom;

        // Reset with random inputs, then release with an all-zero bus
        step(1'b1, 6'($urandom), rand_instr(), $urandom, "reset_a");
        step(1'b0, 6'd0, '0, $urandom, "reset_b");
        step(1'b0, 6'd0, '0, $urandom, "post_reset");

        // Byte and half loads; each entry checks the load issued one step earlier
        step(1'b0, 6'd0, mk_load(6'b100000, 2'd3, 5'd5), $urandom, "zero_before_lb");
        step(1'b0, 6'd0, mk_load(6'b100100, 2'd3, 5'd5), 32'h80FF7F01, "lb_a3");
        step(1'b0, 6'd0, mk_load(6'b100000, 2'd1, 5'd5), 32'h80FF7F01, "lbu_a3");
        step(1'b0, 6'd0, mk_load(6'b100001, 2'd2, 5'd5), 32'h80FF7F01, "lb_a1");
        step(1'b0, 6'd0, mk_load(6'b100101, 2'd0, 5'd5), 32'h8001F00F, "lh_a2");
        step(1'b0, 6'd0, mk_load(6'b100011, 2'd1, 5'd5), 32'h8001F00F, "lhu_a0");
        step(1'b0, 6'd0, mk_load(6'b100011, 2'd0, 5'd7), 32'h8001F00F, "lw_a1");

        // Stall hold: the lw keeps its first-cycle data while SRAM changes
        step(1'b0, 6'b011000, mk_alu(32'h11111111), 32'h12345678, "hold_first");
        step(1'b0, 6'b011000, mk_alu(32'h11111111), 32'hDEADBEEF, "hold_2");
        step(1'b0, 6'b011000, mk_alu(32'h11111111), 32'hDEADBEEF, "hold_3");
        step(1'b0, 6'd0,      mk_alu(32'h22222222), 32'hDEADBEEF, "hold_release");

        // Bubble, then pass-through of an ALU op with HI/LO write, then a store
        pt          = mk_alu(32'hCAFEBABE);
        pt.hl_we    = 1'b1;
        pt.hl_waddr = 2'b10;
        pt.hl_wdata = 64'h1;
        st          = rand_instr();
        st.rf_we    = 1'b0;
        st.ram_en   = 1'b1;
        st.ram_wen  = 4'b1111;
        st.sel      = 1'b0;
        step(1'b0, 6'b001000, pt, $urandom, "after_release");
        step(1'b0, 6'd0, pt, $urandom, "bubble");
        step(1'b0, 6'd0, st, $urandom, "passthrough");
        step(1'b0, 6'd0, '0, $urandom, "store");

        // Reset arriving during a frozen load discards the held data
        step(1'b0, 6'd0, mk_load(6'b100011, 2'd0, 5'd9), $urandom, "pre_rst_stall");
        step(1'b0, 6'b011000, '0, $urandom, "ld_first");
        step(1'b1, 6'b011000, '0, $urandom, "ld_held");
        step(1'b0, 6'd0, '0, $urandom, "rst_mid_stall");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 49) == 0), rand_stall(), rand_instr(), $urandom, "random");
        end

        // Drain the scoreboard within a bounded number of cycles
        repeat (4) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
